// File: rtl/growth_sweep_ctrl_if.sv
// growth_sweep_ctrl_if: depth RAM request/grant bus
// master (controller): mem_req, mem_re, mem_we, mem_addr, mem_wdata out; mem_gnt, mem_rdata in
// slave (RAM side):    mem_gnt, mem_rdata out; the rest in
interface growth_sweep_ctrl_if #(parameter int AW = 8);
    logic          mem_req;
    logic          mem_gnt;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [12:0]   mem_wdata;
    logic [12:0]   mem_rdata;
    modport master(output mem_req, mem_re, mem_we, mem_addr, mem_wdata, input mem_gnt, mem_rdata);
    modport slave(input mem_req, mem_re, mem_we, mem_addr, mem_wdata, output mem_gnt, mem_rdata);
endinterface

// File: rtl/growth_sweep_ctrl.sv
// growth_sweep_ctrl: sweeps the depth map, adds the LUT growth rate per cell, saturates at DMAX
// clk, rst_n      : clock, async active-low reset
// start/busy/done : sweep control and status
// mem             : depth RAM request/grant bus (master side)
// lut_depth/grate : combinational growth-rate LUT lookup
// sat_cnt         : cells that reached DMAX in the current or last sweep
module growth_sweep_ctrl #(
    parameter int          NCELLS = 256,
    parameter int          AW     = 8,
    parameter logic [12:0] DMAX   = 13'h1F80
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    growth_sweep_ctrl_if.master  mem,
    output logic [12:0]          lut_depth,
    input  logic [12:0]          lut_grate,
    output logic [AW:0]          sat_cnt
);
    typedef enum logic [2:0] {IDLE, RD, WT, CALC, WR, DONE} state_t;
    state_t        state, state_nx;
    logic [AW-1:0] addr;
    logic [12:0]   depth_q, new_q;
    logic [13:0]   sum;
    logic          last;
    logic          unused_grate;
    assign unused_grate = ^lut_grate[12:7];
    assign last = addr == AW'(NCELLS - 1);
    assign sum  = {1'b0, depth_q} + {7'b0, lut_grate[6:0]};
    assign busy          = state != IDLE;
    assign done          = state == DONE;
    assign mem.mem_req   = state == RD || state == WR;
    assign mem.mem_re    = state == RD;
    assign mem.mem_we    = state == WR;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = new_q;
    assign lut_depth     = depth_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RD : IDLE;
            RD:      state_nx = mem.mem_gnt ? WT : RD;
            WT:      state_nx = CALC;
            CALC:    state_nx = WR;
            WR:      state_nx = !mem.mem_gnt ? WR : last ? DONE : RD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            depth_q <= '0;
            new_q   <= '0;
            sat_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                addr    <= '0;
                sat_cnt <= '0;
            end
            if (state == WT)
                depth_q <= mem.mem_rdata;
            if (state == CALC) begin
                if (depth_q >= DMAX)
                    new_q <= depth_q;
                else if (sum >= {1'b0, DMAX}) begin
                    new_q   <= DMAX;
                    sat_cnt <= sat_cnt + 1'b1;
                end else
                    new_q <= sum[12:0];
            end
            // the last cell never increments, so addr cannot wrap when NCELLS == 2^AW
            if (state == WR && mem.mem_gnt && !last)
                addr <= addr + 1'b1;
        end
    end
endmodule

// File: doc/growth_sweep_ctrl.md
# growth_sweep_ctrl

Frame-rate controller that walks the terrain depth map and advances each cell by its growth rate. It reads each cell's 13-bit depth from the shared depth RAM and presents it to the existing combinational growth-rate LUT. It then adds the returned rate, saturates the sum at the depth ceiling and writes the result back. All RAM accesses go through a per-access request/grant handshake, so the renderer can keep priority on the RAM.

## Interface
- NCELLS, 256, number of depth-map cells swept per start (1..2^AW)
- AW, 8, depth RAM address width
- DMAX, 8064 (13'h1F80), depth ceiling; cells at or above it are never grown
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse at sweep end
- mem_req  out  1  RAM access request (read or write)
- mem_gnt  in  1  grant; an access completes in a cycle where mem_req & mem_gnt
- mem_re  out  1  read strobe; data valid on mem_rdata the cycle after the granted read
- mem_we  out  1  write strobe
- mem_addr  out  AW  cell address
- mem_wdata  out  13  updated depth
- mem_rdata  in  13  read depth
- lut_depth  out  13  depth presented to the growth-rate LUT
- lut_grate  in  13  LUT result; only bits [6:0] are used, [12:7] ignored
- sat_cnt  out  AW+1  cells that reached DMAX during the current or last sweep

## Operation
- FSM states: IDLE, RD, WT, CALC, WR, DONE.
- IDLE: start=1 → addr<=0, sat_cnt<=0, go to RD. start in any other state is ignored.
- RD: mem_req=1, mem_re=1, mem_addr=addr. mem_gnt=1 → WT; otherwise stay in RD with outputs held.
- WT: depth_q<=mem_rdata → CALC.
- CALC: lut_depth=depth_q (lut_depth is driven from depth_q in all states).
  - sum = {1'b0,depth_q} + lut_grate[6:0], computed at 14 bits.
  - depth_q >= DMAX → new_q <= depth_q (unchanged).
  - otherwise, sum >= DMAX → new_q <= DMAX and sat_cnt increments.
  - otherwise new_q <= sum[12:0].
  - Go to WR.
- WR: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=new_q.
  - No grant → stay in WR.
  - Grant with addr==NCELLS-1 → DONE.
  - Grant otherwise → addr<=addr+1, go to RD.
- DONE: done=1 for one cycle → IDLE.
- Never assert mem_re and mem_we in the same cycle.
- mem_req is low in IDLE, WT, CALC and DONE.
- Outside RD and WR: mem_addr holds the current addr; mem_wdata holds new_q.
- sat_cnt holds its value after DONE until the next accepted start.
- A start pulse arriving in the DONE cycle is ignored.

## Timing
- Reset values (rst_n=0, asynchronous):
  - state=IDLE, addr=0, depth_q=0, new_q=0, sat_cnt=0.
  - busy=0, done=0, mem_req=0, mem_re=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, lut_depth=0.
- Reset in the middle of a sweep aborts immediately. Cells already written stay written; no partial write is issued.
- With mem_gnt tied high, each cell takes exactly 4 cycles (RD, WT, CALC, WR).
- With mem_gnt tied high and start accepted at edge 0:
  - the first RD is in cycle 1;
  - done is high in cycle 4·NCELLS+1;
  - busy is high in cycles 1..4·NCELLS+1.
- Each cycle of grant denial adds exactly one cycle and leaves all other behaviour unchanged.
- The LUT is combinational. lut_grate is sampled only in CALC, one full cycle after depth_q is loaded.
- Address wrap: addr never exceeds NCELLS-1. With NCELLS=2^AW the final increment is suppressed, so addr does not wrap to 0 mid-sweep.

## Test plan
- Basic growth (NCELLS=4, gnt=1). Depths 0, 1000, 3744, 8000.
  - Written: 2, 1127, 3820, 8003.
  - done in cycle 17; sat_cnt=0.
- Saturation: depths 8063, 8064, 8100, 8026.
  - Written: 8064, 8064, 8100, 8028.
  - sat_cnt=1.
- Grant stalls: gnt low for 3 cycles in the first RD and 2 cycles in the last WR.
  - done arrives 5 cycles later than the no-stall case.
  - Write data is identical to the no-stall case; mem_re and mem_we are never high together.
- Start ignored: start pulsed mid-sweep and in the DONE cycle.
  - No restart, addr sequence stays 0..N-1, and exactly one done per accepted start.
- Reset mid-sweep: rst_n low during the WR of cell 2.
  - All outputs are at reset values in the same cycle.
  - Cells 0-1 are updated, cells 2-3 are unchanged.
  - A new start performs a full sweep.
- Full-size wrap (NCELLS=256, AW=8): addresses 0..255 appear once each, in order, with no write to address 0 after cell 255.
